// File: rtl/if_id_stage_buffer_if.sv
// Fetch/hazard-side bundle for the IF/ID stage buffer.
// The fetch unit, hazard unit and decoder (master) talk to the buffer (slave).
interface if_id_stage_buffer_if #(
  parameter int OPCODE_W    = 4,
  parameter int OPND_W      = 4,
  parameter int NUM_OPND    = 3,
  parameter int PC_W        = 8,
  parameter int STALL_CNT_W = 8
) ();
  logic                         hazard;
  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [PC_W-1:0]              pc;
  logic [OPCODE_W-1:0]          opcode;
  logic [NUM_OPND*OPND_W-1:0]   operands;
  logic                         out_valid;
  logic [PC_W-1:0]              pc_o;
  logic [OPCODE_W-1:0]          opcode_o;
  logic [NUM_OPND*OPND_W-1:0]   operands_o;
  logic [STALL_CNT_W-1:0]       stall_cnt;

  modport master (
    output hazard, flush, in_valid, pc, opcode, operands,
    input  in_ready, out_valid, pc_o, opcode_o, operands_o, stall_cnt
  );

  modport slave (
    input  hazard, flush, in_valid, pc, opcode, operands,
    output in_ready, out_valid, pc_o, opcode_o, operands_o, stall_cnt
  );
endinterface

// File: rtl/if_id_stage_buffer.sv
// IF/ID stage buffer: 2-entry elastic store (main + skid) with flush-to-bubble
// and a saturating count of stalled output cycles.
module if_id_stage_buffer #(
  parameter int OPCODE_W    = 4,
  parameter int OPND_W      = 4,
  parameter int NUM_OPND    = 3,
  parameter int PC_W        = 8,
  parameter int STALL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  if_id_stage_buffer_if.slave   bus
);
  localparam int OPS_W  = NUM_OPND * OPND_W;
  localparam int BEAT_W = PC_W + OPCODE_W + OPS_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HOLD1 = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [BEAT_W-1:0]      main_q, main_d;
  logic [BEAT_W-1:0]      skid_q, skid_d;
  logic                   in_ready_q, in_ready_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [BEAT_W-1:0]      in_beat;
  logic                   out_valid;
  logic                   accept;
  logic                   consume;

  // Beat layout: {pc, opcode, operand[NUM_OPND-1] .. operand[0]}
  assign in_beat[BEAT_W-1 -: PC_W]      = bus.pc;
  assign in_beat[OPS_W +: OPCODE_W]     = bus.opcode;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPND; gi++) begin : g_opnd
      assign in_beat[gi*OPND_W +: OPND_W]        = bus.operands[gi*OPND_W +: OPND_W];
      assign bus.operands_o[gi*OPND_W +: OPND_W] = main_q[gi*OPND_W +: OPND_W];
    end
  endgenerate

  assign out_valid     = (state_q != ST_EMPTY);
  assign accept        = bus.in_valid & in_ready_q;
  assign consume       = out_valid & ~bus.hazard;

  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready_q;
  assign bus.pc_o      = main_q[BEAT_W-1 -: PC_W];
  assign bus.opcode_o  = main_q[OPS_W +: OPCODE_W];
  assign bus.stall_cnt = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      // Squash to a NOP bubble; any beat offered this cycle is dropped.
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_HOLD1;
            main_d  = in_beat;
          end
        end
        ST_HOLD1: begin
          if (accept && consume) begin
            main_d = in_beat;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_beat;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d = ST_HOLD1;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign in_ready_d = (state_d != ST_FULL);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && bus.hazard && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
